// File: rtl/mdma_18bx2048_ram_rsp.sv
// SECDED-protected 18b x 2048 simple-dual-port RAM, responder side.
// Optional error injection on writes: define MDMA_RAM_ERR_INJ_EN.
module mdma_18bx2048_ram_rsp #(
    parameter int DEPTH  = 2048,
    parameter int DW     = 18,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      wadr,
    input  logic             wen,
    input  logic [DW-1:0]    wdat,
`ifdef MDMA_RAM_ERR_INJ_EN
    input  logic             inj_sbe,
    input  logic             inj_dbe,
`endif
    input  logic             ren,
    input  logic [10:0]      radr,
    output logic [DW-1:0]    rdat,
    output logic             rsbe,
    output logic             rdbe,
    output logic [CNT_W-1:0] sbe_cnt,
    output logic [CNT_W-1:0] dbe_cnt
);

    localparam int CW = DW + 6;
    localparam int HW = DW + 5;

    // Hamming positions 1..HW; powers of two hold check bits, the rest data.
    function automatic logic [HW:0] spread(input logic [DW-1:0] d);
        logic [HW:0] h;
        int j;
        h = '0;
        j = 0;
        for (int p = 1; p <= HW; p++) begin
            if ((p & (p - 1)) != 0) begin
                h[p[4:0]] = d[j[4:0]];
                j++;
            end
        end
        return h;
    endfunction

    function automatic logic [DW-1:0] gather(input logic [HW:0] h);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p <= HW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j[4:0]] = h[p[4:0]];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [4:0] hchk(input logic [HW:0] h);
        logic [4:0] c;
        c = '0;
        for (int k = 0; k < 5; k++) begin
            for (int p = 1; p <= HW; p++) begin
                if (((p >> k) & 1) != 0) c[k[2:0]] = c[k[2:0]] ^ h[p[4:0]];
            end
        end
        return c;
    endfunction

    function automatic logic [5:0] ecc_f(input logic [DW-1:0] d);
        logic [4:0] c;
        c = hchk(spread(d));
        return {^{c, d}, c};
    endfunction

    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] inj_mask;

`ifdef MDMA_RAM_ERR_INJ_EN
    assign inj_mask = inj_dbe ? CW'(3) : (inj_sbe ? CW'(1) : '0);
`else
    assign inj_mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (wen) mem_q[wadr] <= {ecc_f(wdat), wdat} ^ inj_mask;
    end

    logic          s1_vld_q;
    logic [CW-1:0] s1_cw_q;

    // Nonblocking array read gives read-first on same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_cw_q  <= '0;
        end else begin
            s1_vld_q <= ren;
            if (ren) s1_cw_q <= mem_q[radr];
        end
    end

    logic [DW-1:0] cd;
    logic [4:0]    cc;
    logic          cp;
    logic [HW:0]   h;
    logic [4:0]    syn;
    logic          perr;
    logic [DW-1:0] dec_dat;
    logic          dec_sbe;
    logic          dec_dbe;

    assign {cp, cc, cd} = s1_cw_q;

    always_comb begin
        h = spread(cd);
        for (int k = 0; k < 5; k++) h[5'(1 << k)] = cc[k[2:0]];
        syn     = hchk(h);
        perr    = ^s1_cw_q;
        dec_dat = cd;
        dec_sbe = 1'b0;
        dec_dbe = 1'b0;
        if (syn != 5'd0 && perr) begin
            dec_sbe = 1'b1;
            if (syn <= 5'(HW)) dec_dat = gather(h ^ ({{HW{1'b0}}, 1'b1} << syn));
        end else if (syn != 5'd0) begin
            dec_dbe = 1'b1;
        end else if (perr) begin
            dec_sbe = 1'b1;
        end
    end

    logic          src_vld;
    logic [DW-1:0] src_dat;
    logic          src_sbe;
    logic          src_dbe;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_vld_q;
            logic [DW-1:0] s2_dat_q;
            logic          s2_sbe_q;
            logic          s2_dbe_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld_q <= 1'b0;
                    s2_dat_q <= '0;
                    s2_sbe_q <= 1'b0;
                    s2_dbe_q <= 1'b0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_dat_q <= dec_dat;
                        s2_sbe_q <= dec_sbe;
                        s2_dbe_q <= dec_dbe;
                    end
                end
            end
            assign src_vld = s2_vld_q;
            assign src_dat = s2_dat_q;
            assign src_sbe = s2_sbe_q;
            assign src_dbe = s2_dbe_q;
        end else begin : g_lat1
            assign src_vld = s1_vld_q;
            assign src_dat = dec_dat;
            assign src_sbe = dec_sbe;
            assign src_dbe = dec_dbe;
        end
    endgenerate

    logic [DW-1:0]    rdat_q;
    logic             rsbe_q;
    logic             rdbe_q;
    logic [CNT_W-1:0] sbe_cnt_q;
    logic [CNT_W-1:0] dbe_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat_q    <= '0;
            rsbe_q    <= 1'b0;
            rdbe_q    <= 1'b0;
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else if (src_vld) begin
            rdat_q <= src_dat;
            rsbe_q <= src_sbe;
            rdbe_q <= src_dbe;
            if (src_sbe && sbe_cnt_q != '1) sbe_cnt_q <= sbe_cnt_q + 1'b1;
            if (src_dbe && dbe_cnt_q != '1) dbe_cnt_q <= dbe_cnt_q + 1'b1;
        end
    end

    assign rdat    = rdat_q;
    assign rsbe    = rsbe_q;
    assign rdbe    = rdbe_q;
    assign sbe_cnt = sbe_cnt_q;
    assign dbe_cnt = dbe_cnt_q;

endmodule

// File: tb/tb_mdma_18bx2048_ram_rsp.sv
// Scoreboard bench: RD_LAT=1/CNT_W=16 and RD_LAT=2/CNT_W=2 instances
// share stimulus; expectations queued at drive time, popped on completion.
module tb_mdma_18bx2048_ram_rsp;

    typedef struct {
        int          due;
        logic [17:0] dat;
        logic        sbe;
        logic        dbe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] wadr, radr;
    logic        wen, ren;
    logic [17:0] wdat;
`ifdef MDMA_RAM_ERR_INJ_EN
    logic        inj_sbe, inj_dbe;
`endif

    logic [17:0] rdat1, rdat2;
    logic        rsbe1, rdbe1, rsbe2, rdbe2;
    logic [15:0] sbe_cnt1, dbe_cnt1;
    logic [1:0]  sbe_cnt2, dbe_cnt2;

    always #5 clk = ~clk;

    mdma_18bx2048_ram_rsp #(.RD_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wdat(wdat),
`ifdef MDMA_RAM_ERR_INJ_EN
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
`endif
        .ren(ren), .radr(radr), .rdat(rdat1), .rsbe(rsbe1), .rdbe(rdbe1),
        .sbe_cnt(sbe_cnt1), .dbe_cnt(dbe_cnt1)
    );

    mdma_18bx2048_ram_rsp #(.RD_LAT(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wdat(wdat),
`ifdef MDMA_RAM_ERR_INJ_EN
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
`endif
        .ren(ren), .radr(radr), .rdat(rdat2), .rsbe(rsbe2), .rdbe(rdbe2),
        .sbe_cnt(sbe_cnt2), .dbe_cnt(dbe_cnt2)
    );

    int          cyc = 0;
    int          pass_cnt = 0;
    int          total = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        last1, last2;
    logic [15:0] es1, ed1;
    logic [1:0]  es2, ed2;
    logic [17:0] mdat [2048];
    logic [1:0]  merr [2048];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                last1 = q1.pop_front();
                if (last1.sbe) es1 = es1 + 16'd1;
                if (last1.dbe) ed1 = ed1 + 16'd1;
                total++;
                if ({rdat1, rsbe1, rdbe1} !== {last1.dat, last1.sbe, last1.dbe})
                    $display("FAIL lat1_read got %h/%b/%b exp %h/%b/%b",
                             rdat1, rsbe1, rdbe1, last1.dat, last1.sbe, last1.dbe);
                else pass_cnt++;
                total++;
                if ({sbe_cnt1, dbe_cnt1} !== {es1, ed1})
                    $display("FAIL lat1_cnt got %0d/%0d exp %0d/%0d",
                             sbe_cnt1, dbe_cnt1, es1, ed1);
                else pass_cnt++;
            end else begin
                total++;
                if ({rdat1, rsbe1, rdbe1} !== {last1.dat, last1.sbe, last1.dbe})
                    $display("FAIL lat1_hold got %h/%b/%b exp %h/%b/%b",
                             rdat1, rsbe1, rdbe1, last1.dat, last1.sbe, last1.dbe);
                else pass_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (q2.size() > 0 && q2[0].due == cyc) begin
                last2 = q2.pop_front();
                if (last2.sbe && es2 != 2'b11) es2 = es2 + 2'd1;
                if (last2.dbe && ed2 != 2'b11) ed2 = ed2 + 2'd1;
                total++;
                if ({rdat2, rsbe2, rdbe2} !== {last2.dat, last2.sbe, last2.dbe})
                    $display("FAIL lat2_read got %h/%b/%b exp %h/%b/%b",
                             rdat2, rsbe2, rdbe2, last2.dat, last2.sbe, last2.dbe);
                else pass_cnt++;
                total++;
                if ({sbe_cnt2, dbe_cnt2} !== {es2, ed2})
                    $display("FAIL lat2_cnt got %0d/%0d exp %0d/%0d",
                             sbe_cnt2, dbe_cnt2, es2, ed2);
                else pass_cnt++;
            end else begin
                total++;
                if ({rdat2, rsbe2, rdbe2} !== {last2.dat, last2.sbe, last2.dbe})
                    $display("FAIL lat2_hold got %h/%b/%b exp %h/%b/%b",
                             rdat2, rsbe2, rdbe2, last2.dat, last2.sbe, last2.dbe);
                else pass_cnt++;
            end
        end
    end

    task automatic drive(input logic w, input logic [10:0] wa, input logic [17:0] wd,
                         input logic r, input logic [10:0] ra,
                         input logic is, input logic id);
        exp_t e;
        wen  = w;
        wadr = wa;
        wdat = wd;
        ren  = r;
        radr = ra;
`ifdef MDMA_RAM_ERR_INJ_EN
        inj_sbe = is;
        inj_dbe = id;
`endif
        if (r) begin
            e.dat = mdat[ra];
            e.sbe = (merr[ra] == 2'd1);
            e.dbe = (merr[ra] == 2'd2);
            e.due = cyc + 2;
            q1.push_back(e);
            e.due = cyc + 3;
            q2.push_back(e);
        end
        if (w) begin
            mdat[wa] = id ? (wd ^ 18'h3) : wd;
            merr[wa] = id ? 2'd2 : (is ? 2'd1 : 2'd0);
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
`ifdef MDMA_RAM_ERR_INJ_EN
        inj_sbe = 1'b0;
        inj_dbe = 1'b0;
`endif
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        last1 = '{0, 18'h0, 1'b0, 1'b0};
        last2 = '{0, 18'h0, 1'b0, 1'b0};
        es1 = '0;
        ed1 = '0;
        es2 = '0;
        ed2 = '0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (q1.size() != 0 || q2.size() != 0)
            $display("FAIL %s_timeout pending %0d/%0d exp 0/0", nm, q1.size(), q2.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rdat1, rsbe1, rdbe1, sbe_cnt1, dbe_cnt1} !== 36'h0)
            $display("FAIL reset_u1 got %h/%b/%b/%0d/%0d exp 0", rdat1, rsbe1, rdbe1,
                     sbe_cnt1, dbe_cnt1);
        else pass_cnt++;
        total++;
        if ({rdat2, rsbe2, rdbe2, sbe_cnt2, dbe_cnt2} !== 24'h0)
            $display("FAIL reset_u2 got %h/%b/%b/%0d/%0d exp 0", rdat2, rsbe2, rdbe2,
                     sbe_cnt2, dbe_cnt2);
        else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        drive(1'b1, 11'd5, 18'h2ABCD, 1'b0, 11'd0, 1'b0, 1'b0);
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd5, 1'b0, 1'b0);
        drain("basic");
    endtask

    task automatic test_read_first();
        drive(1'b1, 11'd7, 18'h00001, 1'b0, 11'd0, 1'b0, 1'b0);
        drive(1'b1, 11'd7, 18'h3FFFF, 1'b1, 11'd7, 1'b0, 1'b0);
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd7, 1'b0, 1'b0);
        drain("read_first");
    endtask

`ifdef MDMA_RAM_ERR_INJ_EN
    task automatic test_inject();
        drive(1'b1, 11'd9, 18'h12345, 1'b0, 11'd0, 1'b1, 1'b0);
        drive(1'b1, 11'd10, 18'h12345, 1'b0, 11'd0, 1'b0, 1'b1);
        drive(1'b1, 11'd11, 18'h0ABCD, 1'b0, 11'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd9, 1'b0, 1'b0);
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd10, 1'b0, 1'b0);
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd11, 1'b0, 1'b0);
        drain("inject");
        total++;
        if (sbe_cnt2 !== 2'd3)
            $display("FAIL sbe_sat got %0d exp 3", sbe_cnt2);
        else pass_cnt++;
        total++;
        if (sbe_cnt1 !== 16'd5)
            $display("FAIL sbe_cnt16 got %0d exp 5", sbe_cnt1);
        else pass_cnt++;
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd5, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if ({rdat1, rsbe1, rdbe1, rdat2, rsbe2, rdbe2} !== 40'h0)
            $display("FAIL reset_mid got %h/%h exp 0/0", rdat1, rdat2);
        else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive(1'b0, 11'd0, 18'h0, 1'b1, 11'd5, 1'b0, 1'b0);
        drain("reset_mid");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2048; i++)
            drive(1'b1, 11'(i), 18'(i), 1'b0, 11'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2048; i++)
            drive(1'b0, 11'd0, 18'h0, 1'b1, 11'(i), 1'b0, 1'b0);
        drain("b2b");
    endtask

    initial begin
        wen  = 1'b0;
        ren  = 1'b0;
        wadr = '0;
        radr = '0;
        wdat = '0;
`ifdef MDMA_RAM_ERR_INJ_EN
        inj_sbe = 1'b0;
        inj_dbe = 1'b0;
`endif
        test_reset();
        test_basic();
        test_read_first();
`ifdef MDMA_RAM_ERR_INJ_EN
        test_inject();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
